// File: rtl/gmm_pkg.sv
// Shared types and index-width helpers for the GMM frame sequencer.
package gmm_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // Index width that stays at least one bit when only one entry exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_VARIABLE_DEF = 4;
    localparam int N_MIX_DEF      = 4;
    localparam int V_IDX_W        = idx_w(N_VARIABLE_DEF);
    localparam int M_IDX_W        = idx_w(N_MIX_DEF);

endpackage

// File: rtl/gmm_proc_seq_if.sv
// Sample-in, parameter-addressing, datapath-control and result bus of the sequencer.
interface gmm_proc_seq_if #(
    parameter int D_WIDTH    = 16,
    parameter int N_VARIABLE = 4,
    parameter int N_MIX      = 4
);
    import gmm_pkg::*;

    localparam int V_W = idx_w(N_VARIABLE);
    localparam int M_W = idx_w(N_MIX);

    logic                   s_valid;
    logic                   s_ready;
    logic [D_WIDTH-1:0]     s_r;
    logic [D_WIDTH-1:0]     s_i;
    logic [M_W-1:0]         m_idx;
    logic [V_W-1:0]         v_idx;
    logic [D_WIDTH-1:0]     x_r;
    logic [D_WIDTH-1:0]     x_i;
    logic                   ce;
    logic                   g_rst;
    logic                   y_sload;
    logic                   k_sload;
    logic [2*D_WIDTH-1:0]   p_in_r;
    logic [2*D_WIDTH-1:0]   p_in_i;
    logic                   res_valid;
    logic                   res_ready;
    logic [2*D_WIDTH-1:0]   res_r;
    logic [2*D_WIDTH-1:0]   res_i;

    modport slave (
        input  s_valid, s_r, s_i, p_in_r, p_in_i, res_ready,
        output s_ready, m_idx, v_idx, x_r, x_i, ce, g_rst, y_sload, k_sload,
               res_valid, res_r, res_i
    );

    modport master (
        output s_valid, s_r, s_i, p_in_r, p_in_i, res_ready,
        input  s_ready, m_idx, v_idx, x_r, x_i, ce, g_rst, y_sload, k_sload,
               res_valid, res_r, res_i
    );

endinterface

// File: rtl/gmm_strobe_dly.sv
// Clock-enable gated single-bit delay line; the output is masked while ce is low.
module gmm_strobe_dly #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ce_i,
    input  logic din_i,
    output logic dout_o
);

    logic [DEPTH-1:0] sh_q;
    logic [DEPTH-1:0] sh_d;

    // Truncating the concatenation drops the oldest bit and works for DEPTH == 1.
    assign sh_d   = DEPTH'({sh_q, din_i});
    assign dout_o = sh_q[DEPTH-1] & ce_i;

    // Shift register advancing only on enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else if (ce_i) begin
            sh_q <= sh_d;
        end else begin
            sh_q <= sh_q;
        end
    end

endmodule

// File: rtl/gmm_proc_seq.sv
// GMM frame sequencer: buffers one sample vector, replays it once per mixture,
// drives delay-matched datapath strobes and holds the final probability for handoff.
module gmm_proc_seq
    import gmm_pkg::*;
#(
    parameter int D_WIDTH    = 16,
    parameter int N_VARIABLE = 4,
    parameter int N_MIX      = 4,
    parameter int Y_LAT      = 2,
    parameter int K_LAT      = 5,
    parameter int P_LAT      = 6
) (
    input  logic               clk,
    input  logic               rst,
    gmm_proc_seq_if.slave      bus
);

    localparam int V_W    = idx_w(N_VARIABLE);
    localparam int M_W    = idx_w(N_MIX);
    localparam int T_W    = idx_w(N_MIX * N_VARIABLE);
    localparam int DC_W   = idx_w(P_LAT);
    localparam int T_LAST = N_MIX * N_VARIABLE - 1;

    state_e               state_q, state_d;
    logic [V_W-1:0]       ld_cnt_q;
    logic [T_W-1:0]       t_cnt_q;
    logic [DC_W-1:0]      dr_cnt_q;
    logic                 g_rst_q;
    logic [D_WIDTH-1:0]   smp_r_q [N_VARIABLE];
    logic [D_WIDTH-1:0]   smp_i_q [N_VARIABLE];
    logic [D_WIDTH-1:0]   x_r_q, x_i_q;
    logic [2*D_WIDTH-1:0] res_r_q, res_i_q;

    logic                 s_ready_s, ce_s, res_valid_s;
    logic                 accept_s, ld_last_s, run_last_s, dr_last_s;
    logic                 y_iss_s, k_iss_s;
    logic [V_W-1:0]       v_idx_s;

    assign v_idx_s    = t_cnt_q[V_W-1:0];
    assign accept_s   = bus.s_valid & s_ready_s;
    assign ld_last_s  = accept_s & (ld_cnt_q == V_W'(N_VARIABLE - 1));
    assign run_last_s = (state_q == ST_RUN) & (t_cnt_q == T_W'(T_LAST));
    assign dr_last_s  = (state_q == ST_DRAIN) & (dr_cnt_q == DC_W'(P_LAT - 1));
    assign y_iss_s    = (state_q == ST_RUN) & (v_idx_s == '0);
    assign k_iss_s    = (state_q == ST_RUN) & (t_cnt_q == '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (ld_last_s) state_d = ST_RUN;   else state_d = ST_LOAD;
            ST_RUN:   if (run_last_s) state_d = ST_DRAIN; else state_d = ST_RUN;
            ST_DRAIN: if (dr_last_s) state_d = ST_OUT;   else state_d = ST_DRAIN;
            ST_OUT:   if (res_valid_s && bus.res_ready) state_d = ST_LOAD; else state_d = ST_OUT;
            default:  state_d = ST_LOAD;
        endcase
    end

    // State-decoded handshake and enable outputs.
    always_comb begin
        s_ready_s   = 1'b0;
        ce_s        = 1'b0;
        res_valid_s = 1'b0;
        case (state_q)
            ST_LOAD:  s_ready_s   = 1'b1;
            ST_RUN:   ce_s        = 1'b1;
            ST_DRAIN: ce_s        = 1'b1;
            ST_OUT:   res_valid_s = 1'b1;
            default:  s_ready_s   = 1'b0;
        endcase
    end

    // Sample buffer, counters, replay register and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt_q <= '0;
            t_cnt_q  <= '0;
            dr_cnt_q <= '0;
            g_rst_q  <= 1'b0;
            x_r_q    <= '0;
            x_i_q    <= '0;
            res_r_q  <= '0;
            res_i_q  <= '0;
            for (int i = 0; i < N_VARIABLE; i++) begin
                smp_r_q[i] <= '0;
                smp_i_q[i] <= '0;
            end
        end else begin
            g_rst_q <= ld_last_s;
            if (accept_s) begin
                smp_r_q[ld_cnt_q] <= bus.s_r;
                smp_i_q[ld_cnt_q] <= bus.s_i;
                ld_cnt_q          <= ld_cnt_q + V_W'(1);
            end
            // The run counter holds its final value so m_idx/v_idx stay put through DRAIN.
            if (ld_last_s) begin
                t_cnt_q <= '0;
            end else if ((state_q == ST_RUN) && !run_last_s) begin
                t_cnt_q <= t_cnt_q + T_W'(1);
            end
            if (state_q == ST_RUN) begin
                x_r_q    <= smp_r_q[v_idx_s];
                x_i_q    <= smp_i_q[v_idx_s];
                dr_cnt_q <= '0;
            end else if ((state_q == ST_DRAIN) && !dr_last_s) begin
                dr_cnt_q <= dr_cnt_q + DC_W'(1);
            end
            if (dr_last_s) begin
                res_r_q <= bus.p_in_r;
                res_i_q <= bus.p_in_i;
            end
        end
    end

    gmm_strobe_dly #(.DEPTH(Y_LAT)) u_y_dly (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (ce_s),
        .din_i  (y_iss_s),
        .dout_o (bus.y_sload)
    );

    gmm_strobe_dly #(.DEPTH(K_LAT)) u_k_dly (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (ce_s),
        .din_i  (k_iss_s),
        .dout_o (bus.k_sload)
    );

    assign bus.s_ready   = s_ready_s;
    assign bus.ce        = ce_s;
    assign bus.res_valid = res_valid_s;
    assign bus.g_rst     = g_rst_q;
    assign bus.v_idx     = v_idx_s;
    assign bus.m_idx     = M_W'(t_cnt_q >> V_W);
    assign bus.x_r       = x_r_q;
    assign bus.x_i       = x_i_q;
    assign bus.res_r     = res_r_q;
    assign bus.res_i     = res_i_q;

endmodule
